// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4-row x 3-column matrix keypad and reports one debounced key.
//   A column is driven for SCAN_DIV clocks; rows are sampled in the last
//   clock of that slot. Three slots form one 12-bit raw frame. A key vector
//   is accepted after DEBOUNCE_CNT identical consecutive frames.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   key_row   in   [3:0]  row sense, active-high, bit r = row r
//   key_col   out  [2:0]  column drive, one-hot active-high
//   key_data  out  [11:0] debounced one-hot key, key k at bit (12-k), 0 = none
//   key_valid out         one-clock pulse when key_data takes a new key
module keypad_scanner #(
    parameter int SCAN_DIV     = 25000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] key_data,
    output logic        key_valid
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic          slot_last;
    logic          frame_end_p0;
    logic [11:0]   frame_p0;
    logic [11:0]   frame_next;
    logic          frame_multi;
    logic [11:0]   raw_p1;
    logic          vld_p1;
    logic [11:0]   prev_vec;
    logic [CW-1:0] stable_cnt;
    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          raw_onehot;
    logic          raw_zero;
    logic          load_key;
    logic          clr_key;

    // ---- stage p0: column scan and row sampling ----
    assign slot_last    = (slot_cnt == SLOT_LAST);
    assign frame_end_p0 = slot_last && (col_idx == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    always_comb begin
        case (col_idx)
            2'd0:    key_col = 3'b001;
            2'd1:    key_col = 3'b010;
            2'd2:    key_col = 3'b100;
            default: key_col = 3'b001;
        endcase
    end

    // Key k = 3r + c + 1 lives at bit 12 - k = 11 - 3r - c; only the
    // currently driven column's four bits are replaced.
    always_comb begin
        frame_next = frame_p0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (col_idx == 2'(c)) begin
                    frame_next[11 - 3*r - c] = key_row[r];
                end
            end
        end
    end

    assign frame_multi = ($countones(frame_next) > 1);

    // ---- stage p1: completed frame and stability count ----
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_p0   <= '0;
            raw_p1     <= '0;
            vld_p1     <= 1'b0;
            prev_vec   <= '0;
            stable_cnt <= '0;
        end else begin
            vld_p1 <= frame_end_p0;
            if (slot_last) begin
                frame_p0 <= frame_next;
            end
            if (frame_end_p0) begin
                raw_p1   <= frame_next;
                prev_vec <= frame_next;
                // Multi-key frames never build up stability.
                if (frame_multi || (frame_next != prev_vec)) begin
                    stable_cnt <= CW'(1);
                end else if (stable_cnt != STABLE_MAX) begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end
        end
    end

    // ---- stage p2: debounce FSM, decided the cycle after frame end ----
    assign accept     = (stable_cnt == STABLE_MAX);
    assign raw_onehot = $onehot(raw_p1);
    assign raw_zero   = (raw_p1 == 12'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (vld_p1) begin
            case (state)
                IDLE: begin
                    if (raw_onehot) begin
                        state_next = accept ? HELD : PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (raw_zero) begin
                        state_next = IDLE;
                    end else if (raw_onehot && accept) begin
                        state_next = HELD;
                    end
                end
                HELD: begin
                    if (raw_p1 != key_data) begin
                        state_next = (raw_zero && accept) ? IDLE : RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (raw_p1 == key_data) begin
                        state_next = HELD;
                    end else if (raw_zero && accept) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A key is loaded only when entering HELD from the press side, so a
    // bounce back from RELEASE_WAIT never produces a second pulse.
    always_comb begin
        load_key = ((state == IDLE) || (state == PRESS_WAIT)) && (state_next == HELD);
        clr_key  = ((state == HELD) || (state == RELEASE_WAIT)) && (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_data  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= load_key;
            if (load_key) begin
                key_data <= raw_p1;
            end else if (clr_key) begin
                key_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=2.
// A 12-clock frame; presses are applied on frame boundaries so expected
// acceptance cycles are computed by hand from the cycle index after reset.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_data;
    logic        key_valid;
    logic [11:0] pressed;

    int total  = 0;
    int passed = 0;
    int vcount = 0;
    int colbad = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column drive to its row.
    always_comb begin
        key_row = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (key_col[c] && pressed[11 - 3*r - c]) key_row[r] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting key_valid pulses and bad column drives.
    task automatic run_watch(input int n);
        vcount = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (key_valid === 1'b1) vcount++;
            if (!$onehot(key_col)) colbad++;
        end
    endtask

    initial begin
        logic [2:0] exp_col;
        rst = 1'b1;
        pressed = 12'h000;
        step();
        step();
        check("reset_col",   32'(key_col),   32'h1);
        check("reset_data",  32'(key_data),  32'h0);
        check("reset_valid", 32'(key_valid), 32'h0);
        rst = 1'b0;

        // Idle scanning, 10 frames: column walks 001,010,100 every 4 clocks.
        for (int i = 0; i < 120; i++) begin
            exp_col = 3'b001 << ((i / 4) % 3);
            check("idle_col",   32'(key_col),   32'(exp_col));
            check("idle_valid", 32'(key_valid), 32'h0);
            step();
        end
        check("idle_data", 32'(key_data), 32'h0);

        // Key 1 pressed at cycle 120; frames end at 132 and 144 -> shown at 145.
        pressed = 12'h800;
        run_watch(24);
        check("k1_before_data", 32'(key_data), 32'h0);
        check("k1_before_vld",  32'(vcount),   32'h0);
        step();
        check("k1_data",  32'(key_data),  32'h800);
        check("k1_valid", 32'(key_valid), 32'h1);
        step();
        check("k1_pulse_end", 32'(key_valid), 32'h0);
        run_watch(22);
        check("k1_held_data", 32'(key_data), 32'h800);
        check("k1_held_vld",  32'(vcount),   32'h0);
        pressed = 12'h000;
        run_watch(36);
        check("k1_rel_data", 32'(key_data), 32'h0);
        check("k1_rel_vld",  32'(vcount),   32'h0);

        // Key 12 pressed at cycle 204; accepted at 229.
        pressed = 12'h001;
        run_watch(24);
        check("k12_before_data", 32'(key_data), 32'h0);
        step();
        check("k12_data",  32'(key_data),  32'h001);
        check("k12_valid", 32'(key_valid), 32'h1);
        run_watch(11);
        check("k12_held_vld", 32'(vcount), 32'h0);
        // Released at 240; zero frames end at 252 and 264 -> cleared at 265.
        pressed = 12'h000;
        run_watch(24);
        check("k12_relwait_data", 32'(key_data), 32'h001);
        check("k12_relwait_vld",  32'(vcount),   32'h0);
        step();
        check("k12_clear_data",  32'(key_data),  32'h0);
        check("k12_clear_valid", 32'(key_valid), 32'h0);
        run_watch(11);

        // Key 5 bouncing one frame on, one frame off, for six frames.
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            pressed = 12'h080;
            run_watch(12);
            check("k5_bounce_on_vld", 32'(vcount), 32'h0);
            pressed = 12'h000;
            run_watch(12);
            check("k5_bounce_off_vld", 32'(vcount), 32'h0);
        end
        check("k5_bounce_data", 32'(key_data), 32'h0);

        // Keys 1 and 2 together for five frames: never accepted.
        pressed = 12'hC00;
        run_watch(60);
        check("k12multi_data", 32'(key_data), 32'h0);
        check("k12multi_vld",  32'(vcount),   32'h0);
        // Key 2 released at 408: key 1 accepted at 433.
        pressed = 12'h800;
        run_watch(24);
        check("multi_rel_before", 32'(key_data), 32'h0);
        step();
        check("multi_rel_data",  32'(key_data),  32'h800);
        check("multi_rel_valid", 32'(key_valid), 32'h1);
        pressed = 12'h000;
        run_watch(35);
        check("multi_rel_clear", 32'(key_data), 32'h0);
        check("multi_rel_vld",   32'(vcount),   32'h0);
        run_watch(12);

        // Key 3 at cycle 480; reset pulsed during PRESS_WAIT at cycle 496.
        pressed = 12'h200;
        run_watch(16);
        check("k3_pw_data", 32'(key_data), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("k3_rst_col",   32'(key_col),   32'h1);
        check("k3_rst_data",  32'(key_data),  32'h0);
        check("k3_rst_valid", 32'(key_valid), 32'h0);
        run_watch(24);
        check("k3_fresh_before", 32'(key_data), 32'h0);
        check("k3_fresh_vld",    32'(vcount),   32'h0);
        step();
        check("k3_data",  32'(key_data),  32'h200);
        check("k3_valid", 32'(key_valid), 32'h1);

        check("col_onehot_always", 32'(colbad), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000: clocks per column slot (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive identical frames needed to accept a key vector (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_row  input  4  row sense, active-high, bit r = row r.
REQ-006 SHALL have port key_col  output  3  column drive, one-hot active-high, bit c = column c.
REQ-007 SHALL have port key_data  output  12  debounced one-hot key code; key k (1..12) = bit (12-k), key 1 = 12'b1000_0000_0000; all-zero = no key.
REQ-008 SHALL have port key_valid  output  1  one-clock pulse when key_data takes a new non-zero value.

Function
REQ-009 Key numbering SHALL be k = 3*r + c + 1 (row r 0..3, column c 0..2): keys 1-9, 10 (*), 11 (0), 12 (#).
REQ-010 Slot counter SHALL count 0..SCAN_DIV-1, then wrap to 0 and advance column index 0->1->2->0.
REQ-011 key_col SHALL equal one-hot of the current column index in every cycle, with no all-zero or multi-hot cycle.
REQ-012 key_row SHALL be sampled only in the last cycle of a slot (slot count = SCAN_DIV-1), into the 4 frame bits for that column.
REQ-013 A frame SHALL end at the sample of column 2; its 12-bit raw vector is then complete (frame length 3*SCAN_DIV clocks).
REQ-014 At frame end, raw vector SHALL be compared with previous frame vector: equal -> stable counter increments (saturating at DEBOUNCE_CNT); differ -> stable counter set to 1 and previous vector updated.
REQ-015 A vector SHALL be accepted when stable counter reaches DEBOUNCE_CNT; key_data updates on the clock after that frame end.
REQ-016 Debounce FSM states SHALL be IDLE (key_data=0), PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-017 IDLE -> PRESS_WAIT on frame end with a one-hot raw vector; PRESS_WAIT -> HELD on acceptance (key_data <= vector, key_valid = 1 one cycle); PRESS_WAIT -> IDLE if raw becomes zero before acceptance.
REQ-018 HELD -> RELEASE_WAIT on frame end with raw differing from key_data; RELEASE_WAIT -> IDLE on acceptance of all-zero (key_data <= 0, no pulse); RELEASE_WAIT -> HELD if raw returns to key_data.
REQ-019 Multi-key raw vectors (2+ bits set) SHALL never be accepted; in any state they hold key_data unchanged and reset stable counter to 1.
REQ-020 A direct change from one accepted key to another SHALL require passing through IDLE (release first); key_valid SHALL never fire twice for one held key.
REQ-021 Acceptance and a new frame sample in the same cycle SHALL not occur (acceptance is one cycle after frame end); scanning SHALL continue uninterrupted in all FSM states.

Reset
REQ-022 While rst=1 at a clock edge: slot counter 0, column index 0, key_col=3'b001, frame and previous vectors 0, stable counter 0, FSM IDLE, key_data=0, key_valid=0.
REQ-023 rst asserted mid-frame or mid-debounce SHALL discard partial frame and pending acceptance; scanning restarts at column 0 on the first cycle after rst deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-024 Reset then idle rows=0 for 10 frames -> key_col cycles 001,010,100 every 4 clocks; key_data=0, key_valid never 1.
REQ-025 Hold row0 high only while column 0 driven (key 1) -> key_data=12'b1000_0000_0000 and single key_valid pulse one clock after end of 2nd full frame; stays while held.
REQ-026 Hold key 12 (row3, col2) then release -> key_data=12'b0000_0000_0001 after 2 frames; after release, key_data=0 one clock after 2nd zero frame, no pulse.
REQ-027 Key 5 (row1,col1) bouncing 1 frame on, 1 off, repeated 6 frames -> key_data stays 0, no key_valid.
REQ-028 Keys 1 and 2 pressed together for 5 frames -> key_data unchanged (0), no key_valid; then release key 2 -> key 1 accepted after 2 frames.
REQ-029 rst pulsed for 1 clock during PRESS_WAIT of key 3 -> key_data=0, key_col=001 next cycle; key 3 accepted only after 2 fresh full frames.
